shared_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit asynchronously-reset register bank among NUM_REQ requesters.
- Grants one requester at a time and writes that requester's data into the shared register while it is granted.
- Supports a lock request so a requester can hold ownership for a bounded burst of up to MAX_HOLD cycles.
- Sits between multiple producer blocks and a single shared state register, for example a config or status register.

---
 rtl/shared_reg_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/shared_reg_arbiter.sv | 113 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shared_reg_arb_pkg : types and width helpers for the shared         |
// | register arbiter.                          Revision: 1.0            |
// +--------------------------------------------------------------------+
package shared_reg_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold the value max_hold itself.
   function automatic int cnt_w(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational rotating-priority one-hot picker.        |
// |                                             Revision: 1.0           |
// +--------------------------------------------------------------------+
module rr_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [idx_w(NUM_REQ)-1:0]   start_i,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic [idx_w(NUM_REQ)-1:0]   idx_o,
   output logic                        valid_o
);

   localparam int c_idx_w = idx_w(NUM_REQ);

   logic [c_idx_w-1:0] w_j;

   // Walk from the farthest offset back to the start so the nearest hit wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      w_j     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_j = c_idx_w'((int'(start_i) + off) % NUM_REQ);
         if (req_i[w_j]) begin
            gnt_o      = '0;
            gnt_o[w_j] = 1'b1;
            idx_o      = w_j;
            valid_o    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shared_reg_arbiter : round-robin owner of one shared register with  |
// | bounded lock bursts.                        Revision: 1.0           |
// +--------------------------------------------------------------------+
module shared_reg_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            lock_i,
   input  logic [NUM_REQ*DATA_W-1:0]     data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          wr_en_o,
   output logic [DATA_W-1:0]             q_o,
   output logic [$clog2(NUM_REQ)-1:0]    owner_o,
   output logic                          busy_o
);

   localparam int c_idx_w = idx_w(NUM_REQ);
   localparam int c_cnt_w = cnt_w(MAX_HOLD);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [DATA_W-1:0]    r_q;
   logic [c_idx_w-1:0]   r_owner;
   logic [c_idx_w-1:0]   r_ptr;
   logic [c_cnt_w-1:0]   r_hold;

   logic [DATA_W-1:0]    w_data [NUM_REQ];
   logic [NUM_REQ-1:0]   w_pick_gnt;
   logic [c_idx_w-1:0]   w_pick_idx;
   logic [c_idx_w-1:0]   w_pick_next;
   logic                 w_pick_valid;
   logic                 w_release;
   logic                 w_wr_en;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_data[k] = data_i[k*DATA_W +: DATA_W];
   end

   // r_ptr always tracks (last owner + 1), or 0 straight out of reset.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req_i),
      .start_i (r_ptr),
      .gnt_o   (w_pick_gnt),
      .idx_o   (w_pick_idx),
      .valid_o (w_pick_valid)
   );

   assign w_pick_next = (w_pick_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
   assign w_wr_en     = |(r_gnt & req_i);
   assign w_release   = !req_i[r_owner] || !lock_i[r_owner] ||
                        (r_hold == c_cnt_w'(MAX_HOLD));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_q     <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
      end else begin
         if (w_wr_en) begin
            r_q <= w_data[r_owner];
         end
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_state <= GRANT;
                  r_gnt   <= w_pick_gnt;
                  r_owner <= w_pick_idx;
                  r_ptr   <= w_pick_next;
                  r_hold  <= c_cnt_w'(1);
               end
            end
            GRANT: begin
               if (!w_release) begin
                  r_hold <= r_hold + c_cnt_w'(1);
               end else if (w_pick_valid) begin
                  r_gnt   <= w_pick_gnt;
                  r_owner <= w_pick_idx;
                  r_ptr   <= w_pick_next;
                  r_hold  <= c_cnt_w'(1);
               end else begin
                  r_state <= IDLE;
                  r_gnt   <= '0;
                  r_hold  <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
               r_hold  <= '0;
            end
         endcase
      end
   end

   assign gnt_o   = r_gnt;
   assign wr_en_o = w_wr_en;
   assign q_o     = r_q;
   assign owner_o = r_owner;
   assign busy_o  = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shared_reg_arbiter : directed and random checks of the shared    |
// | register arbiter against an ownership-level model. Revision: 1.0    |
// +--------------------------------------------------------------------+
module tb_shared_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   lock = '0;
   logic [N*W-1:0] data = '0;
   logic [N-1:0]   gnt;
   logic           wr_en;
   logic [W-1:0]   q;
   logic [1:0]     owner;
   logic           busy;

   int errors = 0;
   int checks = 0;

   // Ownership-level model: who owns, for how long, and what was last written.
   bit         m_busy;
   bit         m_fresh;
   int         m_owner;
   int         m_hold;
   logic [W-1:0] m_q;

   shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .reset   (reset),
      .req_i   (req),
      .lock_i  (lock),
      .data_i  (data),
      .gnt_o   (gnt),
      .wr_en_o (wr_en),
      .q_o     (q),
      .owner_o (owner),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int s);
      for (int o = 0; o < N; o++) begin
         int j;
         j = (s + o) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_gnt();
      return m_busy ? N'(1 << m_owner) : '0;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_fresh = 1'b1;
      m_owner = 0;
      m_hold  = 0;
      m_q     = '0;
   endtask

   task automatic model_edge();
      int w;
      if (m_busy) begin
         if (req[m_owner]) m_q = data[m_owner*W +: W];
         if (!req[m_owner] || !lock[m_owner] || m_hold == MH) begin
            w = pick(req, (m_owner + 1) % N);
            if (w >= 0) begin
               m_owner = w;
               m_hold  = 1;
            end else begin
               m_busy = 1'b0;
               m_hold = 0;
            end
         end else begin
            m_hold++;
         end
      end else begin
         w = pick(req, m_fresh ? 0 : (m_owner + 1) % N);
         if (w >= 0) begin
            m_busy  = 1'b1;
            m_fresh = 1'b0;
            m_owner = w;
            m_hold  = 1;
         end
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".gnt"},   32'(gnt),   32'(m_gnt()));
      chk({tag, ".q"},     32'(q),     32'(m_q));
      chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
      chk({tag, ".busy"},  32'(busy),  32'(m_busy));
   endtask

   // Called at posedge+1 with new inputs applied; returns at the next posedge+1.
   task automatic cyc(input string tag);
      #1;
      chk({tag, ".wr_en"}, 32'(wr_en), 32'(|(m_gnt() & req)));
      @(posedge clk);
      model_edge();
      #1;
      chk_outputs(tag);
   endtask

   // Reset is raised between edges so its asynchronous effect is visible at once.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk_outputs(tag);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset("por");

      // Single requester, no lock: regrants itself through the wrap-around.
      req = 4'b0001; lock = 4'b0000; data = 32'h000000A5;
      cyc("t1a"); chk("t1.gnt1", 32'(gnt), 32'h1);
      cyc("t1b"); chk("t1.q",    32'(q),   32'hA5);
      chk("t1.gnt2", 32'(gnt), 32'h1);
      #1; chk("t1.wr_en", 32'(wr_en), 32'h1);
      cyc("t1c");

      // Fairness with every requester active.
      do_reset("t2rst");
      req = 4'b1111; data = 32'h44332211;
      cyc("t2a"); chk("t2.g0", 32'(gnt), 32'h1); chk("t2.q0", 32'(q), 32'h00);
      cyc("t2b"); chk("t2.g1", 32'(gnt), 32'h2); chk("t2.q1", 32'(q), 32'h11);
      cyc("t2c"); chk("t2.g2", 32'(gnt), 32'h4); chk("t2.q2", 32'(q), 32'h22);
      cyc("t2d"); chk("t2.g3", 32'(gnt), 32'h8); chk("t2.q3", 32'(q), 32'h33);
      cyc("t2e"); chk("t2.g4", 32'(gnt), 32'h1); chk("t2.q4", 32'(q), 32'h44);

      // Lock limited to MAX_HOLD cycles.
      do_reset("t3rst");
      req = 4'b0011; lock = 4'b0001; data = 32'h0000BBAA;
      for (int i = 0; i < 4; i++) begin
         cyc("t3hold"); chk("t3.hold", 32'(gnt), 32'h1);
      end
      cyc("t3b"); chk("t3.handoff", 32'(gnt), 32'h2);
      cyc("t3c"); chk("t3.back",    32'(gnt), 32'h1);

      // Owner drops request during a locked grant.
      do_reset("t4rst");
      req = 4'b0100; lock = 4'b0100; data = 32'h00770000;
      cyc("t4a"); cyc("t4b");
      chk("t4.q_before", 32'(q), 32'h77);
      req = 4'b1000; data = 32'h55990000;
      #1; chk("t4.wr_en_drop", 32'(wr_en), 32'h0);
      cyc("t4c");
      chk("t4.q_held", 32'(q), 32'h77); chk("t4.next", 32'(gnt), 32'h8);

      // Reset in the middle of a grant.
      do_reset("t5rst");
      req = 4'b0001; lock = 4'b0001; data = 32'h0000003C;
      cyc("t5a"); cyc("t5b");
      chk("t5.q_pre", 32'(q), 32'h3C);
      do_reset("t5mid");
      chk("t5.busy", 32'(busy), 32'h0);
      req = 4'b1010; lock = 4'b0000;
      cyc("t5c"); chk("t5.first", 32'(gnt), 32'h2);

      // Return to idle, then resume from the pointer after owner 3.
      do_reset("t6rst");
      req = 4'b1000; lock = 4'b1000;
      cyc("t6a");
      req = 4'b0000;
      cyc("t6b");
      chk("t6.busy", 32'(busy), 32'h0); chk("t6.owner", 32'(owner), 32'h3);
      chk("t6.gnt",  32'(gnt),  32'h0);
      req = 4'b1001;
      cyc("t6c"); chk("t6.resume", 32'(gnt), 32'h1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            do_reset("rrst");
         end else begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            lock = N'($urandom | $urandom);
            data = $urandom;
            cyc("rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
